// File: rtl/irq_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer: FSM encoding, sizing limits
// and default handler-vector layout.
package irq_sequencer_pkg;

  localparam int N_IRQ_MAX = 16;
  localparam int IRQ_ID_W  = 4;

  localparam logic [31:0] VECTOR_BASE_DEF   = 32'h0000_0100;
  localparam logic [31:0] VECTOR_STRIDE_DEF = 32'h0000_0010;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENTER  = 2'd1,
    S_ACTIVE = 2'd2,
    S_RETURN = 2'd3
  } irq_state_e;

  // Handler address for a given irq index, truncated to the PC width by the caller.
  function automatic logic [31:0] vectorAddr(input logic [IRQ_ID_W-1:0] id,
                                             input logic [31:0] base,
                                             input logic [31:0] stride);
    return base + (32'(id) * stride);
  endfunction

endpackage

// File: rtl/irq_sequencer_priority_enc.sv
// Fixed-priority encoder: lowest set index of the eligible vector wins.
module irq_sequencer_priority_enc
  import irq_sequencer_pkg::*;
#(
  parameter int N_IRQ = 4
) (
  input  logic [N_IRQ-1:0]    eligible_i,
  output logic                valid_o,
  output logic [IRQ_ID_W-1:0] id_o
);

  // Scan high to low so the last hit, the lowest index, is what remains.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible_i[i]) begin
        valid_o = 1'b1;
        id_o    = IRQ_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt entry/return sequencer: latches irq edges, picks a safe cycle to
// enter the single-level handler and drives the PC redirect pulses.
module irq_sequencer
  import irq_sequencer_pkg::*;
#(
  parameter int          N_IRQ         = 4,
  parameter int          PC_WIDTH      = 32,
  parameter logic [31:0] VECTOR_BASE   = VECTOR_BASE_DEF,
  parameter logic [31:0] VECTOR_STRIDE = VECTOR_STRIDE_DEF
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [N_IRQ-1:0]    irq_in,
  input  logic                irq_enable_in,
  input  logic [N_IRQ-1:0]    irq_mask_in,
  input  logic [PC_WIDTH-1:0] pc_EX_in,
  input  logic                stall_IF_ID_signal_in,
  input  logic                flush_ID_signal_in,
  input  logic                return_instr_signal_in,
  output logic                interrupt_signal_out,
  output logic                return_interrupt_signal_out,
  output logic                pc_load_signal_out,
  output logic [PC_WIDTH-1:0] pc_target_out,
  output logic                irq_active_out,
  output logic [3:0]          irq_id_out,
  output logic [N_IRQ-1:0]    irq_pending_out
);

  irq_state_e            state_q, state_d;
  logic [N_IRQ-1:0]      pending_q, pending_d;
  logic [N_IRQ-1:0]      irqPrev_q;
  logic [PC_WIDTH-1:0]   savedPc_q, savedPc_d;
  logic [IRQ_ID_W-1:0]   irqId_q, irqId_d;

  logic [N_IRQ-1:0]      eligible;
  logic [N_IRQ-1:0]      riseEdges;
  logic [N_IRQ-1:0]      clearMask;
  logic                  winValid;
  logic [IRQ_ID_W-1:0]   winId;
  logic                  takeIrq;
  logic [31:0]           vecFull;

  assign eligible  = irq_enable_in ? (pending_q & irq_mask_in) : '0;
  assign riseEdges = irq_in & ~irqPrev_q;

  irq_sequencer_priority_enc #(
    .N_IRQ(N_IRQ)
  ) u_prio (
    .eligible_i(eligible),
    .valid_o   (winValid),
    .id_o      (winId)
  );

  // Entry only from IDLE and only when the pipeline is not already stalling or flushing.
  assign takeIrq   = (state_q == S_IDLE) && winValid &&
                     !stall_IF_ID_signal_in && !flush_ID_signal_in;
  assign clearMask = takeIrq ? (N_IRQ'(1) << winId) : '0;

  always_comb begin
    state_d   = state_q;
    pending_d = (pending_q & ~clearMask) | riseEdges;
    savedPc_d = savedPc_q;
    irqId_d   = irqId_q;
    unique case (state_q)
      S_IDLE: begin
        if (takeIrq) begin
          state_d   = S_ENTER;
          savedPc_d = pc_EX_in;
          irqId_d   = winId;
        end
      end
      S_ENTER:  state_d = S_ACTIVE;
      S_ACTIVE: begin
        if (return_instr_signal_in) begin
          state_d = S_RETURN;
        end
      end
      S_RETURN: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      irqPrev_q <= '0;
      savedPc_q <= '0;
      irqId_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      irqPrev_q <= irq_in;
      savedPc_q <= savedPc_d;
      irqId_q   <= irqId_d;
    end
  end

  assign vecFull = vectorAddr(irqId_q, VECTOR_BASE, VECTOR_STRIDE);

  // Outputs are decoded purely from registered state.
  always_comb begin
    interrupt_signal_out        = 1'b0;
    return_interrupt_signal_out = 1'b0;
    pc_load_signal_out          = 1'b0;
    pc_target_out               = '0;
    irq_active_out              = 1'b0;
    unique case (state_q)
      S_ENTER: begin
        interrupt_signal_out = 1'b1;
        pc_load_signal_out   = 1'b1;
        pc_target_out        = PC_WIDTH'(vecFull);
      end
      S_ACTIVE: irq_active_out = 1'b1;
      S_RETURN: begin
        return_interrupt_signal_out = 1'b1;
        pc_load_signal_out          = 1'b1;
        pc_target_out               = savedPc_q;
      end
      default: ;
    endcase
  end

  assign irq_id_out      = irqId_q;
  assign irq_pending_out = pending_q;

  aEnterThenActive: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    (state_q == S_ENTER) |=> (state_q == S_ACTIVE));
  aReturnThenIdle: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    (state_q == S_RETURN) |=> (state_q == S_IDLE));
  aPulsesExclusive: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    !(interrupt_signal_out && return_interrupt_signal_out));
  aLineCount: assert property (@(posedge clk_in) (N_IRQ >= 1) && (N_IRQ <= N_IRQ_MAX));

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
Interrupt entry/return controller for the 5-stage RISC-V core. It latches external interrupt edges, applies masks and fixed priority, and picks a safe cycle to take an interrupt. It then drives the one-cycle interrupt/return pulses that the hazard unit turns into stalls and flushes, and supplies the PC redirect (handler vector on entry, saved PC on return). Only one interrupt level exists; there is no nesting.

Parameters:
N_IRQ, 4, number of interrupt lines (1..16)
PC_WIDTH, 32, PC width
VECTOR_BASE, 32'h0000_0100, address of the handler for irq 0
VECTOR_STRIDE, 32'h0000_0010, byte spacing between handler vectors

Ports:
clk_in  input  1  system clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
irq_in  input  N_IRQ  raw interrupt lines, rising-edge significant, already synchronous to clk_in
irq_enable_in  input  1  global interrupt enable (CSR)
irq_mask_in  input  N_IRQ  per-line enable, 1 = enabled
pc_EX_in  input  PC_WIDTH  PC of the instruction in EX; becomes the return address
stall_IF_ID_signal_in  input  1  hazard-unit stall is active, so entry is deferred
flush_ID_signal_in  input  1  branch/jump flush is active, so entry is deferred
return_instr_signal_in  input  1  decoded mret-type return in ID
interrupt_signal_out  input-to-hazard  1  entry pulse (output)
return_interrupt_signal_out  output  1  return pulse
pc_load_signal_out  output  1  PC mux selects pc_target_out this cycle
pc_target_out  output  PC_WIDTH  redirect address
irq_active_out  output  1  handler in progress
irq_id_out  output  4  index of the active or last-taken irq
irq_pending_out  output  N_IRQ  current pending register

Behaviour:
- Reset (async, rst_n_in=0): state=IDLE; pending, irq_prev, saved_pc and irq_id are all 0; every output is 0.
- Edge capture: irq_prev <= irq_in every cycle. A bit of irq_in high while the same bit of irq_prev is low sets that pending bit at that posedge.
- A pending bit is cleared only when that irq is taken.
- A new edge in the same cycle as the clear of the same bit: set wins.
- eligible = pending & irq_mask_in, gated by irq_enable_in. Winner = lowest set index of eligible.
- FSM states: IDLE, ENTER, ACTIVE, RETURN. State is registered; outputs are decoded from state and registers (Moore). No output depends combinationally on inputs.
- IDLE -> ENTER when eligible != 0, stall_IF_ID_signal_in=0 and flush_ID_signal_in=0. At that edge:
  - saved_pc <= pc_EX_in
  - irq_id <= winner
  - pending[winner] <= 0
- If a stall or flush is active, remain in IDLE. Retry every cycle with no lost requests.
- ENTER (exactly 1 cycle):
  - interrupt_signal_out=1, pc_load_signal_out=1
  - pc_target_out = VECTOR_BASE + irq_id*VECTOR_STRIDE, truncated to PC_WIDTH
  - Next state is ACTIVE unconditionally.
- ACTIVE:
  - irq_active_out=1
  - New edges still latch into pending; no new entry is taken (no nesting).
  - return_instr_signal_in=1 -> RETURN.
- RETURN (exactly 1 cycle):
  - return_interrupt_signal_out=1, pc_load_signal_out=1, pc_target_out=saved_pc
  - Next state is IDLE. A pending eligible irq may be taken from IDLE on the following cycle (minimum 1 IDLE cycle between handlers).
- return_instr_signal_in outside ACTIVE is ignored; no pulse is generated.
- irq_enable_in or mask deasserted while ACTIVE: no effect on the current handler; the return still completes.
- Latency: an edge sampled at posedge k sets pending after k. If eligible at posedge k+1, ENTER is high for the cycle after k+1. Minimum edge-to-pulse latency is 2 cycles.
- irq_id_out holds its value after return until the next entry. pc_target_out is 0 when pc_load_signal_out=0.
- Reset asserted mid-ENTER/ACTIVE/RETURN: immediate return to reset values; pending edges are lost.

Decomposition:
- Shared package (core defines header): FSM state encoding (2-bit, IDLE=0, ENTER=1, ACTIVE=2, RETURN=3), N_IRQ max constant, vector base and stride constants.
- One natural sub-module: irq_priority_enc (N_IRQ eligible vector -> valid bit + 4-bit lowest-index winner), purely combinational.
- The FSM, pending register and PC capture stay in the top.

Test Plan:
1. Reset, irq_enable=1, mask=4'b1111, pulse irq_in[2] with pc_EX=0x40 -> exactly 2 cycles later interrupt_signal_out=1 and pc_load=1 for 1 cycle, pc_target=0x120, irq_id=2, pending[2]=0.
2. From ACTIVE with saved_pc=0x40, assert return_instr one cycle -> next cycle return_interrupt_signal_out=1, pc_target=0x40, irq_active_out=0 after.
3. irq_in[3] and irq_in[1] rise together -> irq 1 taken first (target 0x110). After its return, irq 3 is taken after 1 IDLE cycle (target 0x130).
4. Eligible irq while stall_IF_ID_signal_in held high for 3 cycles -> no pulse during the stall; entry on the first cycle the stall is low, capturing the pc_EX_in of that cycle.
5. irq_in[0] edge while ACTIVE, and the same with mask[0]=0 -> pending[0] set, no entry until RETURN. With mask 0 it never enters; entry follows when the mask is set to 1.
6. Assert rst_n_in low during ACTIVE -> all outputs and pending go to 0 immediately (asynchronously). return_instr pulsed afterwards in IDLE -> no return pulse.
